sample_discriminator_config_sequencer: RTL and testbench

// - Shadows sample discriminator config words (thresholds, delays, trigger select, disable mask) and commits them atomically.
// - On commit: holds the discriminator in reset state, drains its delay pipeline, swaps shadow->active, settles, releases.
// - Sits between the PS-side config path (already in adc_clk domain) and the sample_discriminator config inputs.

---
 rtl/rx_pkg.sv | 27 ++
 rtl/tx_pkg.sv | 4 +
 rtl/sample_discriminator_config_sequencer_shadow_reg.sv | 29 ++
 rtl/sample_discriminator_config_sequencer.sv | 118 +++++++++++
 tb/tb_sample_discriminator_config_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Receive-side constants plus the discriminator config bundle and sequencer state encoding.
package rx_pkg;
   localparam int CHANNELS         = 4;
   localparam int SAMPLE_WIDTH     = 16;
   localparam int SRC_BITS         = $clog2(CHANNELS + tx_pkg::CHANNELS);
   localparam int MAX_DELAY_CYCLES = 64;
   localparam int TIMER_BITS       = $clog2(MAX_DELAY_CYCLES);

   localparam int THRESH_W = 2 * CHANNELS * SAMPLE_WIDTH;
   localparam int DELAY_W  = 3 * CHANNELS * TIMER_BITS;
   localparam int TSEL_W   = CHANNELS * SRC_BITS;

   // Per channel: thresholds {high, low}, delays {digital, stop, start}; channel 0 in the LSBs.
   typedef struct packed {
      logic [THRESH_W-1:0] thresholds;
      logic [DELAY_W-1:0]  delays;
      logic [TSEL_W-1:0]   tsel;
      logic [CHANNELS-1:0] dis_mask;
   } disc_cfg_t;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_DRAIN  = 2'd1,
      SEQ_APPLY  = 2'd2,
      SEQ_SETTLE = 2'd3
   } seq_state_e;
endpackage

// File: rtl/tx_pkg.sv
// Transmit-side constants shared with the receive config path.
package tx_pkg;
   localparam int CHANNELS = 4;
endpackage

// File: rtl/sample_discriminator_config_sequencer_shadow_reg.sv
// Shadow register loaded by valid/ready; the active copy takes the shadow only on the apply strobe.
module disc_cfg_shadow_reg #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         adc_clk,
   input  logic         adc_reset,
   input  logic [W-1:0] load_data,
   input  logic         load_valid,
   input  logic         load_ready,
   input  logic         apply,
   output logic [W-1:0] active
);

   logic [W-1:0] shadow;

   always_ff @(posedge adc_clk or posedge adc_reset) begin
      if (adc_reset) begin
         shadow <= RST_VAL;
         active <= RST_VAL;
      end else begin
         if (load_valid && load_ready)
            shadow <= load_data;
         if (apply)
            active <= shadow;
      end
   end

endmodule

// File: rtl/sample_discriminator_config_sequencer.sv
// Shadows discriminator config words and commits them atomically: hold, drain, swap, settle, release.
module sample_discriminator_config_sequencer
   import rx_pkg::*;
#(
   parameter int MAX_DELAY_CYCLES = rx_pkg::MAX_DELAY_CYCLES,
   parameter int PIPE_LATENCY     = 4,
   parameter int SETTLE_CYCLES    = 2,
   localparam int TIMER_BITS      = $clog2(MAX_DELAY_CYCLES),
   localparam int CH              = rx_pkg::CHANNELS
) (
   input  logic                           adc_clk,
   input  logic                           adc_reset,
   input  logic [2*CH*SAMPLE_WIDTH-1:0]   thresh_data,
   input  logic                           thresh_valid,
   output logic                           thresh_ready,
   input  logic [3*CH*TIMER_BITS-1:0]     delay_data,
   input  logic                           delay_valid,
   output logic                           delay_ready,
   input  logic [CH*SRC_BITS-1:0]         tsel_data,
   input  logic                           tsel_valid,
   output logic                           tsel_ready,
   input  logic [CH-1:0]                  disable_data,
   input  logic                           disable_valid,
   output logic                           disable_ready,
   input  logic                           commit_valid,
   output logic                           commit_ready,
   output logic [2*CH*SAMPLE_WIDTH-1:0]   thresholds_out,
   output logic [3*CH*TIMER_BITS-1:0]     delays_out,
   output logic [CH*SRC_BITS-1:0]         tsel_out,
   output logic [CH-1:0]                  disable_out,
   output logic                           discriminator_hold,
   output logic                           busy,
   output logic                           commit_done
);

   localparam int CNT_W = $clog2(MAX_DELAY_CYCLES + PIPE_LATENCY + SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DRAIN_INIT  = CNT_W'(MAX_DELAY_CYCLES + PIPE_LATENCY - 1);
   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

   seq_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cfg_rdy;
   logic             commit_fire;
   logic             apply;
   disc_cfg_t        cfg_in;

   assign cfg_in = '{thresholds: thresh_data, delays: delay_data, tsel: tsel_data, dis_mask: disable_data};

   assign thresh_ready  = cfg_rdy;
   assign delay_ready   = cfg_rdy;
   assign tsel_ready    = cfg_rdy;
   assign disable_ready = cfg_rdy;
   assign commit_ready  = cfg_rdy;

   assign commit_fire = commit_valid && cfg_rdy;
   // Swap lands on the last drain edge so the new config is visible throughout APPLY.
   assign apply = (state == SEQ_DRAIN) && (cnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         SEQ_IDLE:   if (commit_fire) state_nxt = SEQ_DRAIN;
         SEQ_DRAIN:  if (cnt == '0)   state_nxt = SEQ_APPLY;
         SEQ_APPLY:                   state_nxt = SEQ_SETTLE;
         SEQ_SETTLE: if (cnt == '0)   state_nxt = SEQ_IDLE;
         default:                     state_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge adc_clk or posedge adc_reset) begin
      if (adc_reset) begin
         state              <= SEQ_IDLE;
         cnt                <= '0;
         cfg_rdy            <= 1'b0;
         busy               <= 1'b0;
         discriminator_hold <= 1'b0;
         commit_done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cfg_rdy     <= (state_nxt == SEQ_IDLE);
         busy        <= (state_nxt != SEQ_IDLE);
         commit_done <= (state == SEQ_SETTLE) && (cnt == '0);
         case (state)
            SEQ_IDLE: begin
               if (commit_fire) begin
                  cnt                <= DRAIN_INIT;
                  discriminator_hold <= 1'b1;
               end
            end
            SEQ_DRAIN:  if (cnt != '0) cnt <= cnt - CNT_W'(1);
            SEQ_APPLY:  cnt <= SETTLE_INIT;
            SEQ_SETTLE: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else           discriminator_hold <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   disc_cfg_shadow_reg #(.W(2*CH*SAMPLE_WIDTH), .RST_VAL('0)) u_thresh (
      .adc_clk, .adc_reset, .load_data(cfg_in.thresholds), .load_valid(thresh_valid),
      .load_ready(cfg_rdy), .apply, .active(thresholds_out));

   disc_cfg_shadow_reg #(.W(3*CH*TIMER_BITS), .RST_VAL('0)) u_delay (
      .adc_clk, .adc_reset, .load_data(cfg_in.delays), .load_valid(delay_valid),
      .load_ready(cfg_rdy), .apply, .active(delays_out));

   disc_cfg_shadow_reg #(.W(CH*SRC_BITS), .RST_VAL('0)) u_tsel (
      .adc_clk, .adc_reset, .load_data(cfg_in.tsel), .load_valid(tsel_valid),
      .load_ready(cfg_rdy), .apply, .active(tsel_out));

   // Disable mask resets to all-ones so the discriminator starts bypassed.
   disc_cfg_shadow_reg #(.W(CH), .RST_VAL('1)) u_disable (
      .adc_clk, .adc_reset, .load_data(cfg_in.dis_mask), .load_valid(disable_valid),
      .load_ready(cfg_rdy), .apply, .active(disable_out));

endmodule

// File: tb/tb_sample_discriminator_config_sequencer.sv
// Scoreboarded bench: stimulus pushes the expected active config per commit; a monitor pops on commit_done.
module tb_sample_discriminator_config_sequencer;
   import rx_pkg::*;

   logic                adc_clk = 1'b0;
   logic                adc_reset = 1'b1;
   logic [THRESH_W-1:0] thresh_data = '0;
   logic                thresh_valid = 1'b0;
   logic                thresh_ready;
   logic [DELAY_W-1:0]  delay_data = '0;
   logic                delay_valid = 1'b0;
   logic                delay_ready;
   logic [TSEL_W-1:0]   tsel_data = '0;
   logic                tsel_valid = 1'b0;
   logic                tsel_ready;
   logic [CHANNELS-1:0] disable_data = '0;
   logic                disable_valid = 1'b0;
   logic                disable_ready;
   logic                commit_valid = 1'b0;
   logic                commit_ready;
   logic [THRESH_W-1:0] thresholds_out;
   logic [DELAY_W-1:0]  delays_out;
   logic [TSEL_W-1:0]   tsel_out;
   logic [CHANNELS-1:0] disable_out;
   logic                discriminator_hold;
   logic                busy;
   logic                commit_done;

   int n_cmp = 0;
   int n_err = 0;
   disc_cfg_t exp_q[$];
   disc_cfg_t sh;

   sample_discriminator_config_sequencer dut (
      .adc_clk(adc_clk), .adc_reset(adc_reset),
      .thresh_data(thresh_data), .thresh_valid(thresh_valid), .thresh_ready(thresh_ready),
      .delay_data(delay_data), .delay_valid(delay_valid), .delay_ready(delay_ready),
      .tsel_data(tsel_data), .tsel_valid(tsel_valid), .tsel_ready(tsel_ready),
      .disable_data(disable_data), .disable_valid(disable_valid), .disable_ready(disable_ready),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .thresholds_out(thresholds_out), .delays_out(delays_out), .tsel_out(tsel_out),
      .disable_out(disable_out), .discriminator_hold(discriminator_hold),
      .busy(busy), .commit_done(commit_done));

   always #5 adc_clk = ~adc_clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (commit_done) seen = 1'b1;
      end
      chk({name, "_commit_done_seen"}, seen, 1);
   endtask

   task automatic commit_push();
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      exp_q.push_back(sh);
   endtask

   // Monitor: compares the active set on every commit_done and guards active stability while released.
   initial begin
      disc_cfg_t e;
      logic [$bits(disc_cfg_t)-1:0] prev_act = '0;
      logic prev_hold = 1'b0;
      logic prev_rst  = 1'b1;
      forever begin
         @(posedge adc_clk);
         #2;
         if (commit_done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_commit_done: got pulse, required none (queue empty)");
            end else begin
               e = exp_q.pop_front();
               chk("sb_thresholds", thresholds_out, e.thresholds);
               chk("sb_delays", delays_out, e.delays);
               chk("sb_tsel", tsel_out, e.tsel);
               chk("sb_disable", disable_out, e.dis_mask);
               chk("sb_hold_released", discriminator_hold, 0);
            end
         end
         if (!adc_reset && !prev_rst && !discriminator_hold && !prev_hold)
            chk("active_stable_while_released",
                {thresholds_out, delays_out, tsel_out, disable_out}, prev_act);
         prev_act  = {thresholds_out, delays_out, tsel_out, disable_out};
         prev_hold = discriminator_hold;
         prev_rst  = adc_reset;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required clean finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      sh = '0;
      sh.dis_mask = '1;

      // Reset held
      repeat (3) tick();
      chk("in_reset_ready", {thresh_ready, delay_ready, tsel_ready, disable_ready, commit_ready}, 0);
      chk("in_reset_hold", discriminator_hold, 0);
      chk("in_reset_busy", busy, 0);
      adc_reset = 1'b0;
      tick();
      chk("rel_disable", disable_out, 4'b1111);
      chk("rel_thresholds", thresholds_out, 0);
      chk("rel_hold", discriminator_hold, 0);
      chk("rel_busy", busy, 0);
      chk("rel_ready", {thresh_ready, delay_ready, tsel_ready, disable_ready, commit_ready}, 5'b11111);

      // Thresholds ch0 {high=1000, low=200} shadowed, not committed
      thresh_data = '0;
      thresh_data[31:0] = {16'd1000, 16'd200};
      thresh_valid = 1'b1;
      tick();
      thresh_valid = 1'b0;
      sh.thresholds = 128'h03E8_00C8;
      ok = 1'b1;
      repeat (100) begin
         tick();
         if (thresholds_out !== '0 || discriminator_hold !== 1'b0) ok = 1'b0;
      end
      chk("no_commit_thresholds_unchanged", ok, 1);

      commit_push();
      chk("commit_hold_rise", discriminator_hold, 1);
      chk("commit_busy", busy, 1);
      chk("commit_ready_low", commit_ready, 0);
      repeat (67) tick();
      chk("thresh_before_apply_67", thresholds_out, 0);
      tick();
      chk("thresh_at_apply_68", thresholds_out, 128'h03E8_00C8);
      repeat (2) tick();
      chk("hold_at_70", discriminator_hold, 1);
      chk("done_at_70", commit_done, 0);
      tick();
      chk("hold_fall_71", discriminator_hold, 0);
      chk("done_pulse_71", commit_done, 1);
      chk("busy_low_71", busy, 0);
      tick();
      chk("done_clear_72", commit_done, 0);

      // Delay word offered during DRAIN waits for IDLE
      commit_push();
      repeat (5) tick();
      delay_data = '0;
      delay_data[5:0] = 6'd10;
      delay_valid = 1'b1;
      tick();
      chk("drain_delay_ready", delay_ready, 0);
      wait_done("drain_word");
      chk("first_idle_delay_ready", delay_ready, 1);
      tick();
      delay_valid = 1'b0;
      sh.delays = 72'd10;
      chk("delay_not_active_yet", delays_out, 0);
      commit_push();
      wait_done("delay_apply");
      chk("delay_start_10_applied", delays_out, 72'd10);

      // Disable word and commit in the same cycle
      disable_data = 4'b0101;
      disable_valid = 1'b1;
      commit_valid = 1'b1;
      tick();
      disable_valid = 1'b0;
      commit_valid = 1'b0;
      sh.dis_mask = 4'b0101;
      exp_q.push_back(sh);
      wait_done("same_cycle");
      chk("same_cycle_disable", disable_out, 4'b0101);

      // Reset 20 cycles into DRAIN
      tsel_data = 12'h123;
      tsel_valid = 1'b1;
      tick();
      tsel_valid = 1'b0;
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      repeat (20) tick();
      chk("pre_reset_hold", discriminator_hold, 1);
      adc_reset = 1'b1;
      #1;
      chk("async_rst_hold", discriminator_hold, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_disable", disable_out, 4'b1111);
      chk("async_rst_thresholds", thresholds_out, 0);
      chk("async_rst_delays", delays_out, 0);
      repeat (3) tick();
      adc_reset = 1'b0;
      sh = '0;
      sh.dis_mask = '1;
      repeat (100) tick();
      commit_push();
      wait_done("post_reset");
      chk("post_reset_tsel_zero", tsel_out, 0);

      // Back-to-back commits with commit_valid held
      thresh_data = '0;
      thresh_data[127:96] = {16'd4000, 16'd50};
      thresh_valid = 1'b1;
      tick();
      thresh_valid = 1'b0;
      sh.thresholds = {32'h0FA0_0032, 96'h0};
      commit_valid = 1'b1;
      tick();
      exp_q.push_back(sh);
      exp_q.push_back(sh);
      wait_done("b2b_first");
      chk("b2b_gap_busy_low", busy, 0);
      chk("b2b_gap_commit_ready", commit_ready, 1);
      tick();
      commit_valid = 1'b0;
      chk("b2b_second_busy", busy, 1);
      chk("b2b_second_hold", discriminator_hold, 1);
      chk("b2b_second_done_clear", commit_done, 0);
      wait_done("b2b_second");

      repeat (5) tick();
      chk("sb_queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
